// File: rtl/iddr_deser_if.sv
// Bus bundle for iddr_deser: DDR data, enable and bitslip in; edge samples and
// the packed word out.
interface iddr_deser_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned RATIO = 2
);
  logic                       CE;
  logic [WIDTH-1:0]           D;
  logic                       slip_i;
  logic [WIDTH-1:0]           Q1;
  logic [WIDTH-1:0]           Q2;
  logic [2*WIDTH*RATIO-1:0]   data_o;
  logic                       valid_o;

  modport master (
    output CE, D, slip_i,
    input  Q1, Q2, data_o, valid_o
  );

  modport slave (
    input  CE, D, slip_i,
    output Q1, Q2, data_o, valid_o
  );
endinterface

// File: rtl/iddr_deser.sv
// Input-DDR capture with selectable Q1/Q2 presentation and a bitslip-aligned
// gearbox packing RATIO edge pairs per output word.
module iddr_deser #(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned RATIO        = 2,
  parameter string       DDR_CLK_EDGE = "SAME_EDGE_PIPELINED"
) (
  input logic          C,
  input logic          R,
  iddr_deser_if.slave  bus_io
);

  localparam int unsigned WordW = 2 * WIDTH * RATIO;
  localparam int unsigned PairW = 2 * WIDTH;
  localparam int unsigned CntW  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam bit          IsOpp  = (DDR_CLK_EDGE == "OPPOSITE_EDGE");
  localparam bit          IsPipe = (DDR_CLK_EDGE == "SAME_EDGE_PIPELINED");

  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_dly_q, fall_dly_d;
  logic [WIDTH-1:0] q1_q, q1_d;
  logic [WIDTH-1:0] q2_q, q2_d;
  logic             primed_q, primed_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] pair_first_q, pair_first_d;
  logic [WIDTH-1:0] pair_second_q, pair_second_d;
  logic             pair_vld_q, pair_vld_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WordW-1:0] acc_q, acc_d;
  logic [WordW-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic [WordW-1:0] word_next;
  int unsigned      slot_base;

  // Falling-edge capture domain.
  always_ff @(negedge C) begin
    if (R) begin
      fall_q <= '0;
    end else if (bus_io.CE) begin
      fall_q <= bus_io.D;
    end
  end

  always_comb begin
    rise_d        = rise_q;
    fall_dly_d    = fall_dly_q;
    q1_d          = q1_q;
    q2_d          = q2_q;
    primed_d      = primed_q;
    phase_d       = phase_q;
    pair_first_d  = pair_first_q;
    pair_second_d = pair_second_q;
    pair_vld_d    = pair_vld_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    data_d        = data_q;
    valid_d       = 1'b0;
    slot_base     = 32'(cnt_q) * PairW;
    word_next     = acc_q;
    word_next[slot_base +: PairW] = {pair_second_q, pair_first_q};

    if (bus_io.CE) begin
      rise_d     = bus_io.D;
      fall_dly_d = fall_q;
      q1_d       = rise_q;
      q2_d       = fall_q;
      primed_d   = 1'b1;

      // rise_q/fall_q hold r(k-1)/f(k-1) here; fall_dly_q holds f(k-2).
      pair_first_d  = phase_q ? fall_dly_q : rise_q;
      pair_second_d = phase_q ? rise_q     : fall_q;
      // Pair built right after reset comes from cleared registers, not data.
      pair_vld_d    = primed_q & ~bus_io.slip_i;

      if (bus_io.slip_i) begin
        phase_d = ~phase_q;
        cnt_d   = '0;
      end else if (pair_vld_q) begin
        if (cnt_q == CntW'(RATIO - 1)) begin
          data_d  = word_next;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          acc_d = word_next;
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      rise_q        <= '0;
      fall_dly_q    <= '0;
      q1_q          <= '0;
      q2_q          <= '0;
      primed_q      <= 1'b0;
      phase_q       <= 1'b0;
      pair_first_q  <= '0;
      pair_second_q <= '0;
      pair_vld_q    <= 1'b0;
      cnt_q         <= '0;
      acc_q         <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
    end else begin
      rise_q        <= rise_d;
      fall_dly_q    <= fall_dly_d;
      q1_q          <= q1_d;
      q2_q          <= q2_d;
      primed_q      <= primed_d;
      phase_q       <= phase_d;
      pair_first_q  <= pair_first_d;
      pair_second_q <= pair_second_d;
      pair_vld_q    <= pair_vld_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
    end
  end

  assign bus_io.Q1      = IsPipe ? q1_q : rise_q;
  assign bus_io.Q2      = IsOpp ? fall_q : q2_q;
  assign bus_io.data_o  = data_q;
  assign bus_io.valid_o = valid_q;

endmodule

// File: tb/tb_iddr_deser.sv
// Randomised and directed bench for iddr_deser: three W4/R2 instances (one per
// DDR_CLK_EDGE mode) and one W1/R1 instance, checked against a sample-history model.
module tb_iddr_deser;

  logic       C;
  logic       R;
  logic       ce;
  logic       slip;
  logic [3:0] d4;

  int n_vec;
  int n_err;

  iddr_deser_if #(.WIDTH(4), .RATIO(2)) if_opp ();
  iddr_deser_if #(.WIDTH(4), .RATIO(2)) if_same ();
  iddr_deser_if #(.WIDTH(4), .RATIO(2)) if_pipe ();
  iddr_deser_if #(.WIDTH(1), .RATIO(1)) if_r1 ();

  assign if_opp.CE      = ce;
  assign if_opp.D       = d4;
  assign if_opp.slip_i  = slip;
  assign if_same.CE     = ce;
  assign if_same.D      = d4;
  assign if_same.slip_i = slip;
  assign if_pipe.CE     = ce;
  assign if_pipe.D      = d4;
  assign if_pipe.slip_i = slip;
  assign if_r1.CE       = ce;
  assign if_r1.D        = d4[0];
  assign if_r1.slip_i   = slip;

  iddr_deser #(.WIDTH(4), .RATIO(2), .DDR_CLK_EDGE("OPPOSITE_EDGE")) u_opp (
    .C(C), .R(R), .bus_io(if_opp)
  );
  iddr_deser #(.WIDTH(4), .RATIO(2), .DDR_CLK_EDGE("SAME_EDGE")) u_same (
    .C(C), .R(R), .bus_io(if_same)
  );
  iddr_deser #(.WIDTH(4), .RATIO(2), .DDR_CLK_EDGE("SAME_EDGE_PIPELINED")) u_pipe (
    .C(C), .R(R), .bus_io(if_pipe)
  );
  iddr_deser #(.WIDTH(1), .RATIO(1), .DDR_CLK_EDGE("SAME_EDGE_PIPELINED")) u_r1 (
    .C(C), .R(R), .bus_io(if_r1)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  // Reference model state; index 0 = W4/R2 stream, index 1 = W1/R1 stream.
  logic [3:0]  r_last [2];
  logic [3:0]  f_last [2];
  logic [3:0]  f_prev [2];
  int          n_rise [2];
  bit          phase  [2];
  logic [3:0]  pend_a [2];
  logic [3:0]  pend_b [2];
  bit          pend_ok[2];
  logic [15:0] wbits  [2];
  int          wcnt   [2];
  logic [15:0] exp_data [2];
  bit          exp_valid[2];
  logic [3:0]  e_opp_q1, e_opp_q2, e_same_q1, e_same_q2, e_pipe_q1, e_pipe_q2;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_pos(input int m, input int w, input int ratio, input bit rst,
                           input bit ce_v, input bit sl, input logic [3:0] dr);
    if (rst) begin
      r_last[m] = '0; f_last[m] = '0; f_prev[m] = '0; n_rise[m] = 0; phase[m] = 1'b0;
      pend_a[m] = '0; pend_b[m] = '0; pend_ok[m] = 1'b0;
      wbits[m] = '0; wcnt[m] = 0; exp_data[m] = '0; exp_valid[m] = 1'b0;
      if (m == 0) begin
        e_opp_q1 = '0; e_same_q1 = '0; e_same_q2 = '0; e_pipe_q1 = '0; e_pipe_q2 = '0;
      end
    end else if (!ce_v) begin
      exp_valid[m] = 1'b0;
    end else begin
      exp_valid[m] = 1'b0;
      if (sl) begin
        wcnt[m]  = 0;
        wbits[m] = '0;
      end else if (pend_ok[m]) begin
        wbits[m] = wbits[m] | (16'(pend_a[m]) << (2 * wcnt[m] * w))
                            | (16'(pend_b[m]) << ((2 * wcnt[m] + 1) * w));
        wcnt[m]++;
        if (wcnt[m] == ratio) begin
          exp_data[m]  = wbits[m];
          exp_valid[m] = 1'b1;
          wcnt[m]      = 0;
          wbits[m]     = '0;
        end
      end
      pend_a[m]  = phase[m] ? f_prev[m] : r_last[m];
      pend_b[m]  = phase[m] ? r_last[m] : f_last[m];
      pend_ok[m] = (n_rise[m] > 0) && !sl;
      if (sl) phase[m] = !phase[m];
      if (m == 0) begin
        e_opp_q1  = dr;
        e_same_q1 = dr;
        e_same_q2 = f_last[m];
        e_pipe_q1 = r_last[m];
        e_pipe_q2 = f_last[m];
      end
      r_last[m] = dr;
      if (n_rise[m] < 4) n_rise[m]++;
    end
  endtask

  task automatic model_neg(input int m, input bit rst, input bit ce_v, input logic [3:0] df);
    if (rst) begin
      f_last[m] = '0;
      f_prev[m] = '0;
      if (m == 0) e_opp_q2 = '0;
    end else if (ce_v) begin
      f_prev[m] = f_last[m];
      f_last[m] = df;
      if (m == 0) e_opp_q2 = df;
    end
  endtask

  task automatic run_cycle(input bit rst, input bit ce_v, input bit sl,
                           input logic [3:0] rv, input logic [3:0] fv);
    R = rst; ce = ce_v; slip = sl; d4 = rv;
    @(posedge C);
    #1;
    model_pos(0, 4, 2, rst, ce_v, sl, rv);
    model_pos(1, 1, 1, rst, ce_v, sl, rv & 4'h1);
    check_eq("opp_q1",     16'(if_opp.Q1),      16'(e_opp_q1));
    check_eq("same_q1",    16'(if_same.Q1),     16'(e_same_q1));
    check_eq("same_q2",    16'(if_same.Q2),     16'(e_same_q2));
    check_eq("pipe_q1",    16'(if_pipe.Q1),     16'(e_pipe_q1));
    check_eq("pipe_q2",    16'(if_pipe.Q2),     16'(e_pipe_q2));
    check_eq("opp_valid",  16'(if_opp.valid_o), 16'(exp_valid[0]));
    check_eq("same_valid", 16'(if_same.valid_o), 16'(exp_valid[0]));
    check_eq("pipe_valid", 16'(if_pipe.valid_o), 16'(exp_valid[0]));
    check_eq("opp_data",   if_opp.data_o,       exp_data[0]);
    check_eq("same_data",  if_same.data_o,      exp_data[0]);
    check_eq("pipe_data",  if_pipe.data_o,      exp_data[0]);
    check_eq("r1_valid",   16'(if_r1.valid_o),  16'(exp_valid[1]));
    check_eq("r1_data",    16'(if_r1.data_o),   exp_data[1]);
    #1;
    d4 = fv;
    @(negedge C);
    #1;
    model_neg(0, rst, ce_v, fv);
    model_neg(1, rst, ce_v, fv & 4'h1);
    check_eq("opp_q2", 16'(if_opp.Q2), 16'(e_opp_q2));
    #1;
  endtask

  function automatic logic [3:0] pat_r(input int p);
    return (p % 2 == 0) ? 4'd1 : 4'd3;
  endfunction

  function automatic logic [3:0] pat_f(input int p);
    return (p % 2 == 0) ? 4'd2 : 4'd4;
  endfunction

  initial begin
    int p;
    n_vec = 0;
    n_err = 0;
    R = 1'b1; ce = 1'b0; slip = 1'b0; d4 = '0;

    for (int i = 0; i < 2; i++) run_cycle(1'b1, 1'b1, 1'b0, 4'($urandom), 4'($urandom));

    // Phase 0 stream 1,2,3,4 repeating.
    p = 0;
    for (int i = 0; i < 8; i++) begin
      run_cycle(1'b0, 1'b1, 1'b0, pat_r(p), pat_f(p));
      if (exp_valid[0]) check_eq("word_ph0", if_pipe.data_o, 16'h4321);
      if (exp_valid[1]) check_eq("r1_word", 16'(if_r1.data_o), 16'h0001);
      p++;
    end

    // Slip on an r=1 cycle: new words start with pair (4,1).
    run_cycle(1'b0, 1'b1, 1'b1, pat_r(p), pat_f(p));
    p++;
    for (int i = 0; i < 9; i++) begin
      run_cycle(1'b0, 1'b1, 1'b0, pat_r(p), pat_f(p));
      if (exp_valid[0]) check_eq("word_ph1", if_pipe.data_o, 16'h3214);
      p++;
    end

    run_cycle(1'b0, 1'b1, 1'b1, pat_r(p), pat_f(p));
    p++;
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b0, 1'b1, 1'b0, pat_r(p), pat_f(p));
      if (exp_valid[0]) check_eq("word_slip2", if_pipe.data_o, 16'h4321);
      p++;
    end

    // Enable low mid-word: the stream must resume without loss.
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b0, 4'($urandom), 4'($urandom));
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b0, 1'b1, 1'b0, pat_r(p), pat_f(p));
      if (exp_valid[0]) check_eq("word_ce", if_pipe.data_o, 16'h4321);
      p++;
    end

    // One-cycle reset mid-word, then a fresh stream.
    run_cycle(1'b0, 1'b1, 1'b0, pat_r(p), pat_f(p));
    run_cycle(1'b1, 1'b1, 1'b1, 4'($urandom), 4'($urandom));
    p = 0;
    for (int i = 0; i < 8; i++) begin
      run_cycle(1'b0, 1'b1, 1'b0, pat_r(p), pat_f(p));
      if (exp_valid[0]) check_eq("word_rst", if_pipe.data_o, 16'h4321);
      p++;
    end

    for (int i = 0; i < 400; i++) begin
      run_cycle($urandom_range(99) < 2, $urandom_range(99) < 85, $urandom_range(99) < 6,
                4'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iddr_deser.md
# iddr_deser

Parametrised input-DDR capture and deserialiser. It samples a WIDTH-bit DDR bus on both edges of a single clock and exposes raw edge pairs on Q1/Q2 in a selectable DDR_CLK_EDGE mode. It also packs aligned pairs into a wide word with a valid strobe and half-cycle bitslip alignment. It sits directly behind the pad-level clock buffer on the Ethernet RX path, for example RGMII nibble capture feeding the MAC byte stream.

## Interface
- WIDTH, 1: DDR bus width in bits.
- RATIO, 2: number of aligned (first, second) sample pairs packed per output word; ≥1.
- DDR_CLK_EDGE, "SAME_EDGE_PIPELINED": Q1/Q2 presentation mode, one of "OPPOSITE_EDGE", "SAME_EDGE", "SAME_EDGE_PIPELINED".
- C  in  1  clock; both edges sample D.
- R  in  1  reset, synchronous, active-high; honoured on both edges of C.
- CE  in  1  clock enable; low makes every register hold, on both edges.
- D  in  WIDTH  DDR data input.
- slip_i  in  1  single-cycle bitslip request, sampled at posedge C.
- Q1  out  WIDTH  rising-edge sample, per mode.
- Q2  out  WIDTH  falling-edge sample, per mode.
- data_o  out  2*WIDTH*RATIO  deserialised word.
- valid_o  out  1  data_o valid; one-cycle pulse per word.

## Operation
- Notation: r(k) is D sampled at posedge k; f(k) is D sampled at the negedge following posedge k.
- Q1/Q2 modes:
  - OPPOSITE_EDGE: Q1 <= r(k) at posedge k; Q2 <= f(k) at that negedge.
  - SAME_EDGE: at posedge k, Q1 <= r(k) and Q2 <= f(k-1).
  - SAME_EDGE_PIPELINED: at posedge k, Q1 <= r(k-1) and Q2 <= f(k-1), giving an aligned pair.
- Gearbox input is always the pipelined-aligned stream, independent of DDR_CLK_EDGE.
  - phase=0: pair = (first r(k-1), second f(k-1)).
  - phase=1: pair = (first f(k-2), second r(k-1)).
- Packing is LSB-first. Slot s = 2*i + j occupies data_o[s*WIDTH +: WIDTH], where i is the pair index 0..RATIO-1 and j is 0 for the first sample, 1 for the second.
- cnt counts 0..RATIO-1 and advances on each CE-enabled posedge.
  - When cnt==RATIO-1: data_o <= completed word, valid_o <= 1, cnt <= 0.
  - Otherwise: valid_o <= 0 and data_o holds its previous value.
- cnt wraps RATIO-1 -> 0 with no gap cycle; a continuous stream yields valid_o every RATIO cycles.
- Bitslip:
  - slip_i=1 with CE=1 at posedge: phase toggles, cnt <= 0, the partial word is discarded, valid_o <= 0 on that edge.
  - The next word starts with the first pair formed under the new phase.
  - Consecutive slip pulses each toggle phase, so two slips restore the original alignment.
- CE=0 at a posedge: valid_o <= 0; every other register holds, and slip_i is ignored. CE=0 at a negedge: the falling-sample register holds.
- Reset: R=1 at any edge clears the registers of that edge.
  - Reset values: Q1=0, Q2=0, data_o=0, valid_o=0, cnt=0, phase=0, all internal sample registers 0.
  - R overrides CE and slip_i.
  - Reset in mid-word discards the partial word; no valid_o is produced for it.

## Timing
- Q1 latency, posedge k to output: OPPOSITE_EDGE and SAME_EDGE 0 cycles (updates at k); SAME_EDGE_PIPELINED 1 cycle.
- Q2 updates at the negedge (OPPOSITE_EDGE) or at posedge k+1 (both SAME modes).
- Word latency: the last sample of a word, taken at posedge or negedge belonging to cycle k, gives valid_o high for exactly the cycle following posedge k+2.
- After R deasserts before posedge m, the first word's first pair uses r(m). Its valid_o follows posedge m+RATIO+1.
- slip_i asserted at posedge k: the first pair of the new word is the one formed at posedge k+1.
- R must be held high across at least one full C period so that both edge domains clear.

## Test plan
- WIDTH=4, RATIO=2, phase 0: drive r=1, f=2, r=3, f=4 continuously repeating.
  - Expect valid_o every 2 cycles with data_o=16'h4321.
  - Expect the first valid_o 2 cycles after the r=3 edge.
- Same stream, with one slip_i pulse inserted between words.
  - Expect one dropped word.
  - Then data_o=16'h3214 (pairs (2,3),(4,1)) every 2 cycles.
  - After a second slip, data_o returns to 16'h4321.
- Each DDR_CLK_EDGE value with stream r=A, f=B, r=C, f=D.
  - OPPOSITE_EDGE: Q1=A at the edge sampling A, and Q2=B at the following negedge.
  - SAME_EDGE: Q1=C while Q2=B.
  - SAME_EDGE_PIPELINED: Q1=A while Q2=B.
- CE held low for 3 cycles mid-word.
  - Expect Q1, Q2, data_o and cnt frozen, and valid_o=0.
  - On re-enable, the word completes with no sample lost or duplicated.
- R pulsed for 1 cycle after the first pair of a word.
  - Expect all outputs 0 the cycle after reset, phase=0, and no valid_o for the aborted word.
  - The next word is packed from the post-reset samples.
- RATIO=1, WIDTH=1: drive a toggling D of 1,0,1,0.
  - Expect valid_o high every cycle with data_o=2'b01.
